// File: rtl/obstacle_scheduler.sv
// Obstacle launch scheduler: paces sprite launches into a pool of updater slots,
// strobes the in-flight slots once per frame and ramps the shared speed.
module obstacle_scheduler #(
  parameter int         NUM_SLOTS   = 3,
  parameter int         MIN_GAP     = 8,
  parameter int         RAMP_FRAMES = 600,
  parameter int         MAX_SPEED   = 8,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_frame_tick,
  input  logic                 i_enable,
  input  logic                 i_hit,
  input  logic [NUM_SLOTS-1:0] i_slot_done,
  output logic [NUM_SLOTS-1:0] o_spawn,
  output logic [NUM_SLOTS-1:0] o_update,
  output logic [3:0]           o_speed,
  output logic [3:0]           o_sprite_id,
  output logic [NUM_SLOTS-1:0] o_active,
  output logic                 o_frozen
);
  localparam int                   GAP_W     = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0]     GAP_LAST  = GAP_W'(MIN_GAP - 1);
  localparam logic [15:0]          RAMP_LAST = 16'(RAMP_FRAMES - 1);
  localparam logic [3:0]           SPEED_MAX = 4'(MAX_SPEED);
  localparam logic [NUM_SLOTS-1:0] SLOT_ONE  = NUM_SLOTS'(1);
  localparam logic [7:0]           LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    WAIT_GAP    = 2'd0,
    WAIT_RANDOM = 2'd1,
    LAUNCH      = 2'd2,
    FROZEN      = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [7:0]           r_lfsr, w_lfsr_nxt;
  logic [GAP_W-1:0]     r_gap_cnt, w_gap_cnt_nxt;
  logic [3:0]           r_delay, w_delay_nxt;
  logic [15:0]          r_ramp_cnt, w_ramp_cnt_nxt;
  logic [NUM_SLOTS-1:0] r_spawn, w_spawn_nxt;
  logic [NUM_SLOTS-1:0] r_update, w_update_nxt;
  logic [NUM_SLOTS-1:0] r_active, w_active_nxt;
  logic [3:0]           r_speed, w_speed_nxt;
  logic [3:0]           r_sprite_id, w_sprite_id_nxt;
  logic                 r_frozen, w_frozen_nxt;

  logic                 w_fe;
  logic [NUM_SLOTS-1:0] w_free;
  logic [NUM_SLOTS-1:0] w_pick;
  logic [7:0]           w_lfsr_step;

  assign w_fe        = i_frame_tick & i_enable;
  assign w_free      = ~r_active;
  // Two's-complement trick isolates the lowest-index free slot.
  assign w_pick      = w_free & (~w_free + SLOT_ONE);
  assign w_lfsr_step = {r_lfsr[6:0], ^(r_lfsr & LFSR_TAPS)};

  always_comb begin
    w_state_nxt     = r_state;
    w_lfsr_nxt      = r_lfsr;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_delay_nxt     = r_delay;
    w_ramp_cnt_nxt  = r_ramp_cnt;
    w_spawn_nxt     = '0;
    w_update_nxt    = '0;
    w_active_nxt    = r_active;
    w_speed_nxt     = r_speed;
    w_sprite_id_nxt = r_sprite_id;
    w_frozen_nxt    = r_frozen;

    if (r_state == FROZEN) begin
      w_frozen_nxt = 1'b1;
    end else if (i_hit) begin
      // Freeze beats a coincident frame tick: no strobes, counters hold.
      w_state_nxt  = FROZEN;
      w_frozen_nxt = 1'b1;
      w_lfsr_nxt   = i_enable ? w_lfsr_step : r_lfsr;
    end else begin
      w_lfsr_nxt   = i_enable ? w_lfsr_step : r_lfsr;
      w_active_nxt = r_active & ~i_slot_done;

      if (w_fe) begin
        w_update_nxt = r_active;
        if (r_ramp_cnt == RAMP_LAST) begin
          w_ramp_cnt_nxt = 16'd0;
          w_speed_nxt    = (r_speed < SPEED_MAX) ? r_speed + 4'd1 : SPEED_MAX;
        end else begin
          w_ramp_cnt_nxt = r_ramp_cnt + 16'd1;
        end
      end else begin
        w_update_nxt = '0;
      end

      case (r_state)
        WAIT_GAP: begin
          if (w_fe && (r_gap_cnt == GAP_LAST)) begin
            w_delay_nxt   = r_lfsr[3:0];
            w_gap_cnt_nxt = '0;
            w_state_nxt   = WAIT_RANDOM;
          end else if (w_fe) begin
            w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
          end else begin
            w_gap_cnt_nxt = r_gap_cnt;
          end
        end
        WAIT_RANDOM: begin
          if (w_fe && (r_delay == 4'd0)) begin
            w_state_nxt = LAUNCH;
          end else if (w_fe) begin
            w_delay_nxt = r_delay - 4'd1;
          end else begin
            w_delay_nxt = r_delay;
          end
        end
        LAUNCH: begin
          // Retries every enabled cycle until a slot frees up.
          if (i_enable && (w_pick != '0)) begin
            w_spawn_nxt     = w_pick;
            w_active_nxt    = w_active_nxt | w_pick;
            w_sprite_id_nxt = {2'b00, r_lfsr[1:0]};
            w_state_nxt     = WAIT_GAP;
          end else begin
            w_state_nxt = LAUNCH;
          end
        end
        default: begin
          w_state_nxt = WAIT_GAP;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state     <= WAIT_GAP;
      r_lfsr      <= LFSR_SEED;
      r_gap_cnt   <= '0;
      r_delay     <= 4'd0;
      r_ramp_cnt  <= 16'd0;
      r_spawn     <= '0;
      r_update    <= '0;
      r_active    <= '0;
      r_speed     <= 4'd1;
      r_sprite_id <= 4'd0;
      r_frozen    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lfsr      <= w_lfsr_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_delay     <= w_delay_nxt;
      r_ramp_cnt  <= w_ramp_cnt_nxt;
      r_spawn     <= w_spawn_nxt;
      r_update    <= w_update_nxt;
      r_active    <= w_active_nxt;
      r_speed     <= w_speed_nxt;
      r_sprite_id <= w_sprite_id_nxt;
      r_frozen    <= w_frozen_nxt;
    end
  end

  assign o_spawn     = r_spawn;
  assign o_update    = r_update;
  assign o_active    = r_active;
  assign o_speed     = r_speed;
  assign o_sprite_id = r_sprite_id;
  assign o_frozen    = r_frozen;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Scoreboard bench for obstacle_scheduler: stimulus queues expected spawn/update
// pulses with their cycle numbers, a negedge monitor pops and compares them.
module tb_obstacle_scheduler;
  localparam int NS = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, tick, en, hit;
  logic [NS-1:0] done, spawn, update, active;
  logic [3:0]    speed, sid;
  logic          frozen;

  obstacle_scheduler #(
    .NUM_SLOTS(NS), .MIN_GAP(8), .RAMP_FRAMES(4), .MAX_SPEED(8), .LFSR_SEED(8'hA5)
  ) dut (
    .i_clock(clk), .i_reset(rst_n), .i_frame_tick(tick), .i_enable(en), .i_hit(hit),
    .i_slot_done(done), .o_spawn(spawn), .o_update(update), .o_speed(speed),
    .o_sprite_id(sid), .o_active(active), .o_frozen(frozen)
  );

  typedef struct {
    int            cyc;
    logic [NS-1:0] val;
    logic [3:0]    sid;
  } exp_t;

  exp_t spq[$];
  exp_t upq[$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  int   cyc      = 0;
  int   ecnt     = 0;
  bit   mon_on   = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    chk_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1 from A5, stepped n times.
  function automatic logic [7:0] adv(input int n);
    logic [7:0] v;
    v = 8'hA5;
    for (int i = 0; i < n; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    return v;
  endfunction

  function automatic void push_sp(input int c, input logic [NS-1:0] v, input logic [3:0] s);
    exp_t x;
    x.cyc = c; x.val = v; x.sid = s;
    spq.push_back(x);
  endfunction

  function automatic void push_up(input int c, input logic [NS-1:0] v);
    exp_t x;
    x.cyc = c; x.val = v; x.sid = 4'd0;
    upq.push_back(x);
  endfunction

  task automatic cyc1(input logic t, input logic e, input logic h, input logic [NS-1:0] d);
    tick = t; en = e; hit = h; done = d;
    @(posedge clk);
    cyc++;
    if (rst_n && e) ecnt++;
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_speed"},  int'(speed),  1);
    chk({tag, "_active"}, int'(active), 0);
    chk({tag, "_frozen"}, int'(frozen), 0);
    chk({tag, "_sprite"}, int'(sid),    0);
    chk({tag, "_spawn"},  int'(spawn),  0);
    chk({tag, "_update"}, int'(update), 0);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (mon_on) begin
      if (spawn != '0) begin
        if (spq.size() == 0) chk("spawn_unexpected", int'(spawn), 0);
        else begin
          x = spq.pop_front();
          chk("spawn_cycle",  cyc,         x.cyc);
          chk("spawn_slot",   int'(spawn), int'(x.val));
          chk("spawn_sprite", int'(sid),   int'(x.sid));
        end
      end
      if (update != '0) begin
        if (upq.size() == 0) chk("update_unexpected", int'(update), 0);
        else begin
          x = upq.pop_front();
          chk("update_cycle", cyc,          x.cyc);
          chk("update_mask",  int'(update), int'(x.val));
        end
      end
    end
  end

  initial begin
    int            m, d, sp, lr;
    int            L[4];
    logic [7:0]    lv;
    logic [NS-1:0] mask;

    rst_n = 1'b0; tick = 1'b0; en = 1'b0; hit = 1'b0; done = '0;
    repeat (3) cyc1(1'b0, 1'b1, 1'b0, 3'b000);
    mon_on = 1'b1;
    chk_reset_state("reset");
    rst_n = 1'b1; cyc = 0; ecnt = 0;

    // Paused warm-up with one disabled tick: nothing may count it.
    for (int i = 1; i <= 10; i++) cyc1(i == 5, 1'b0, 1'b0, 3'b000);

    // Enabled frame k ticks at cycle 10k+10; lfsr before cycle p is adv(p-11).
    m = 0;
    for (int s = 0; s < 4; s++) begin
      lv = adv(10 * m + 79);
      d = int'(lv[3:0]);
      L[s] = m + 9 + d;
      m = L[s];
      if (s < NS) begin
        lv = adv(10 * L[s]);
        push_sp(10 * L[s] + 11, 3'b001 << s, {2'b00, lv[1:0]});
      end
    end

    for (int k = 1; k <= L[3] + 2; k++) begin
      repeat (9) cyc1(1'b0, 1'b1, 1'b0, 3'b000);
      mask = '0;
      for (int s = 0; s < NS; s++) if (L[s] < k) mask[s] = 1'b1;
      if (mask != '0) push_up(10 * k + 10, mask);
      cyc1(1'b1, 1'b1, 1'b0, 3'b000);
      sp = 1 + k / 4;
      if (sp > 8) sp = 8;
      chk("speed_ramp", int'(speed), sp);
    end
    chk("active_full", int'(active), 7);

    // Pause while stuck in launch with all slots busy.
    for (int i = 0; i < 15; i++) begin
      cyc1(i == 7, 1'b0, 1'b0, 3'b000);
      if (i == 7) chk("paused_update", int'(update), 0);
    end
    chk("paused_active", int'(active), 7);
    repeat (2) cyc1(1'b0, 1'b1, 1'b0, 3'b000);

    // Retiring slot 1 lets the pending launch take it on the following cycle.
    lv = adv(ecnt + 1);
    push_sp(cyc + 2, 3'b010, {2'b00, lv[1:0]});
    cyc1(1'b0, 1'b1, 1'b0, 3'b010);
    chk("retire_slot1", int'(active), 5);
    cyc1(1'b0, 1'b1, 1'b0, 3'b000);
    chk("respawn_slot1", int'(active), 7);
    repeat (3) cyc1(1'b0, 1'b1, 1'b0, 3'b000);

    // Hit together with a frame tick while active = 101.
    cyc1(1'b0, 1'b1, 1'b0, 3'b010);
    chk("active_101", int'(active), 5);
    cyc1(1'b0, 1'b1, 1'b0, 3'b000);
    cyc1(1'b1, 1'b1, 1'b1, 3'b000);
    chk("hit_update", int'(update), 0);
    chk("frozen_set", int'(frozen), 1);
    for (int j = 0; j < 100; j++) begin
      cyc1(1'b0, 1'b1, 1'b0, (j == 50) ? 3'b001 : 3'b000);
      cyc1(1'b1, 1'b1, 1'b0, 3'b000);
    end
    chk("frozen_active", int'(active), 5);
    chk("frozen_hold",   int'(frozen), 1);
    chk("frozen_speed",  int'(speed),  8);
    rst_n = 1'b0;
    cyc1(1'b0, 1'b1, 1'b0, 3'b000);
    chk_reset_state("unfreeze");

    // Ticks every second cycle; reset lands on the launch cycle.
    rst_n = 1'b1; cyc = 0; ecnt = 0;
    lv = adv(15);
    lr = 9 + int'(lv[3:0]);
    for (int j = 1; j <= lr; j++) begin
      cyc1(1'b0, 1'b1, 1'b0, 3'b000);
      cyc1(1'b1, 1'b1, 1'b0, 3'b000);
    end
    rst_n = 1'b0;
    cyc1(1'b0, 1'b1, 1'b0, 3'b000);
    chk("midlaunch_spawn",  int'(spawn),  0);
    chk("midlaunch_active", int'(active), 0);
    rst_n = 1'b1; cyc = 0; ecnt = 0;
    lv = adv(2 * lr);
    push_sp(2 * lr + 1, 3'b001, {2'b00, lv[1:0]});
    for (int j = 1; j <= lr; j++) begin
      cyc1(1'b0, 1'b1, 1'b0, 3'b000);
      cyc1(1'b1, 1'b1, 1'b0, 3'b000);
    end
    repeat (3) cyc1(1'b0, 1'b1, 1'b0, 3'b000);
    chk("relaunch_active", int'(active), 1);

    chk("spawn_queue_drained",  spq.size(), 0);
    chk("update_queue_drained", upq.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/obstacle_scheduler.md
Name: obstacle_scheduler

Overview:
- Schedules the obstacle sprites in the game.
- Owns NUM_SLOTS obstacle-updater slots. For each one it decides when to launch it, sends it per-frame move strobes, and retires it when the slot reports it has left the screen.
- Generates the shared speed value, which ramps over time, and a pseudo-random sprite id and launch spacing.
- Sits between the frame-timing logic and the per-slot obstacle position updaters; it is the only source of their update, reset and speed inputs.

Parameters:
- NUM_SLOTS, 3: number of obstacle slots scheduled (1..8).
- MIN_GAP, 8: minimum frames between two launches.
- RAMP_FRAMES, 600: frames per speed increment.
- MAX_SPEED, 8: speed saturation value (1..15).
- LFSR_SEED, 8'hA5: LFSR value loaded at reset; must be non-zero.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- frameTick  in  1  one-cycle pulse, once per video frame.
- enable  in  1  game running; low = pause.
- hit  in  1  collision detected; level or pulse.
- slotDone  in  NUM_SLOTS  per-slot one-cycle pulse: obstacle wrapped off-screen.
- spawn  out  NUM_SLOTS  per-slot one-cycle launch pulse; drives the slot's position reset.
- update  out  NUM_SLOTS  per-slot one-cycle move strobe.
- speed  out  4  shared pixels-per-update.
- spriteId  out  4  sprite id for the slot being launched; valid with spawn.
- active  out  NUM_SLOTS  slot currently in flight.
- frozen  out  1  scheduler halted after a hit.

Behaviour:
- All state is updated on the clock rising edge. reset is sampled only on that edge (synchronous, active-low).
- Reset values:
  - spawn = 0, update = 0, active = 0.
  - speed = 1, spriteId = 0, frozen = 0.
  - lfsr = LFSR_SEED, gapCnt = 0, rampCnt = 0, state = WAIT_GAP.
- Reset overrides every other input in the same cycle, including mid-launch and while frozen.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Advances every clock, except when frozen or when enable is low.
  - Never reaches 0.
- Frame event: fe = frameTick & enable & ~frozen.
  - All counters and launch logic act only on fe.
  - With enable low everything holds, and no update or spawn pulses are emitted.
- Update strobes:
  - On a cycle with fe, update <= active (sampled at that edge) for exactly one cycle, i.e. 1-cycle latency from frameTick.
  - update is 0 in every other cycle.
- Speed ramp:
  - rampCnt increments on each fe.
  - When rampCnt reaches RAMP_FRAMES-1 it wraps to 0, and speed <= min(speed+1, MAX_SPEED).
  - speed never exceeds MAX_SPEED and never decrements except at reset.
- State machine:
  - WAIT_GAP: gapCnt increments on fe. When gapCnt reaches MIN_GAP-1: delay <= lfsr[3:0], gapCnt <= 0, go to WAIT_RANDOM.
  - WAIT_RANDOM: each fe decrements delay. When delay is 0 at an fe, go to LAUNCH. A delay of 0 therefore launches on the next fe.
  - LAUNCH:
    - If any slot is free (~active != 0): pick the lowest-index free slot i. In one cycle, pulse spawn[i], set active[i], set spriteId <= {2'b00, lfsr[1:0]}, and go to WAIT_GAP.
    - If no slot is free: stay in LAUNCH and retry on every cycle; the launch is not tied to fe.
  - FROZEN: entered from any state in the cycle after hit is high. While frozen, update, spawn and all counters are held at 0/held; active and speed are held. Leaving FROZEN is only by reset.
- Retire: slotDone[j] clears active[j] in the next cycle.
  - slotDone on an inactive slot is ignored.
  - If a launch and a slotDone occur in the same cycle, free-slot selection uses the pre-edge active. The launch may not choose slot j in that cycle; both effects are applied.
  - update uses the pre-edge active, so a retiring slot may receive one last strobe in the same cycle as its slotDone.
- Simultaneous events:
  - hit together with fe: the freeze wins; no update or spawn in that cycle.
  - spawn and update to the same slot can never occur in the same cycle, because the new slot is not yet active.
- Widths:
  - gapCnt and delay are sized by clog2 of their limits.
  - rampCnt is 16 bits.
  - All compares are unsigned.

Test Plan:
- Reset and first launch: hold reset low 3 cycles, release, pulse frameTick every 10 cycles with seed A5. Required: speed=1 and active=0 immediately after reset; 8 frames of gap, then lfsr[3:0] frames of random delay; then spawn=001, active=001 and spriteId = that cycle's lfsr[1:0], each for exactly 1 cycle.
- Update strobes: with active=011, pulse frameTick. Required: update=011 for one cycle, exactly 1 cycle after the tick. With enable=0, the same tick produces update=000, and gapCnt/rampCnt are unchanged.
- Slot exhaustion: NUM_SLOTS=3, never assert slotDone. Required: spawns on slots 0, 1 and 2 in that order, then the block stays in LAUNCH. Pulse slotDone[1]; required: active clears bit 1, and spawn[1] follows within 2 cycles.
- Speed ramp: RAMP_FRAMES=4, 40 ticks. Required: speed increments after ticks 4, 8, ... and saturates at 8 from tick 28 on.
- Hit: assert hit in the same cycle as frameTick with active=101. Required: no update in that cycle; frozen=1 next cycle; no further spawn or update for 100 ticks; active remains 101. Reset low for one cycle then restores the reset values.
- Reset mid-launch: drive reset low in the LAUNCH cycle. Required: no spawn pulse, active=0, state=WAIT_GAP.
